// File: rtl/pixel_upscaler_pkg.sv
// Shared types and helpers for the 2x pixel upscaler: output geometry, fetch FSM
// states, RGB565 to RGB888 expansion and the colour-bar test pattern palette.
`timescale 1ns/1ps
package pixel_upscaler_pkg;

    localparam int OUT_W = 640;
    localparam int OUT_H = 480;

    typedef enum logic [1:0] {
        F_IDLE,
        F_FILL,
        F_WAIT
    } fetch_state_t;

    localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
    localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] BAR_RED     = 24'hFF0000;
    localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
    localparam logic [23:0] BAR_BLACK   = 24'h000000;

    // Top bits are replicated into the low bits so full scale maps to 0xFF.
    function automatic logic [23:0] rgb565_to_888(input logic [15:0] px);
        return {px[15:11], px[15:13], px[10:5], px[10:9], px[4:0], px[4:2]};
    endfunction

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/line_bank_ram.sv
// Ping-pong line storage: simple dual-port RAM with registered read; the bank
// select is the address MSB, so both line buffers share one memory.
`timescale 1ns/1ps
module line_bank_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk_25Mhz,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [15:0]       wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [15:0]       rd_data
);

    logic [15:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk_25Mhz) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/pixel_upscaler_2x.sv
// 2x nearest-neighbour upscaler: RGB565 lines from a FWFT FIFO into ping-pong banks,
// RGB888 out. Optional colour bars with PIXEL_UPSCALER_TEST_PATTERN_EN.
`timescale 1ns/1ps
module pixel_upscaler_2x
    import pixel_upscaler_pkg::*;
#(
    parameter int SRC_W = OUT_W / 2,
    parameter int SRC_H = OUT_H / 2
) (
    input  logic        clk_25Mhz,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [15:0] fifo_data,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    input  logic        out_ready,
`ifdef PIXEL_UPSCALER_TEST_PATTERN_EN
    input  logic        test_pattern,
`endif
    output logic [23:0] out_pixel,
    output logic        out_valid,
    output logic        underflow
);

    localparam int XW  = $clog2(SRC_W);
    localparam int OXW = XW + 1;
    localparam int OYW = $clog2(2 * SRC_H);
    localparam int LW  = $clog2(SRC_H + 1);

    fetch_state_t   fetch_state;
    logic [XW-1:0]  wr_x;
    logic [LW-1:0]  src_line;
    logic           fill_bank;
    logic           rd_bank;
    logic [1:0]     bank_full;
    logic [OXW-1:0] out_x;
    logic [OYW-1:0] out_y;
    logic           emit_active;

    logic           wr_en;
    logic           line_done;
    logic           rd_req;
    logic           rd_hit;
    logic           rd_miss;
    logic           req_p0;
    logic           vld_p0;
    logic [15:0]    rd_data_p0;
    logic [23:0]    pix_p1;
    logic           vld_p1;

    always_comb begin
        fifo_rd_en = (fetch_state == F_FILL) && !fifo_empty && !bank_full[fill_bank];
        wr_en      = fifo_rd_en && !frame_start;
        line_done  = wr_en && (wr_x == XW'(SRC_W - 1));
        rd_req     = out_ready && emit_active && !frame_start;
        rd_hit     = rd_req && bank_full[rd_bank];
        rd_miss    = rd_req && !bank_full[rd_bank];
`ifdef PIXEL_UPSCALER_TEST_PATTERN_EN
        if (test_pattern) rd_miss = 1'b0;
`endif
    end

    // Fetch and emit control. Fill completion is applied after the release so a
    // bank that finishes filling on a wrap during underflow is not lost.
    always_ff @(posedge clk_25Mhz) begin
        if (rst) begin
            fetch_state <= F_IDLE;
            wr_x        <= '0;
            src_line    <= '0;
            fill_bank   <= 1'b0;
            rd_bank     <= 1'b0;
            bank_full   <= '0;
            out_x       <= '0;
            out_y       <= '0;
            emit_active <= 1'b0;
            underflow   <= 1'b0;
        end else if (frame_start) begin
            fetch_state <= F_FILL;
            wr_x        <= '0;
            src_line    <= '0;
            fill_bank   <= 1'b0;
            rd_bank     <= 1'b0;
            bank_full   <= '0;
            out_x       <= '0;
            out_y       <= '0;
            emit_active <= 1'b1;
            underflow   <= 1'b0;
        end else begin
            if (rd_req) begin
                if (rd_miss) underflow <= 1'b1;
                if (out_x == OXW'(2 * SRC_W - 1)) begin
                    out_x <= '0;
                    if (out_y[0]) begin
                        bank_full[rd_bank] <= 1'b0;
                        rd_bank            <= ~rd_bank;
                    end
                    if (out_y == OYW'(2 * SRC_H - 1)) begin
                        out_y       <= '0;
                        emit_active <= 1'b0;
                    end else begin
                        out_y <= out_y + 1'b1;
                    end
                end else begin
                    out_x <= out_x + 1'b1;
                end
            end
            if (wr_en) begin
                if (line_done) begin
                    wr_x                 <= '0;
                    fill_bank            <= ~fill_bank;
                    src_line             <= src_line + 1'b1;
                    bank_full[fill_bank] <= 1'b1;
                    if (src_line == LW'(SRC_H - 1)) fetch_state <= F_WAIT;
                end else begin
                    wr_x <= wr_x + 1'b1;
                end
            end
        end
    end

    line_bank_ram #(
        .ADDR_W (XW + 1)
    ) u_ram (
        .clk_25Mhz (clk_25Mhz),
        .wr_en     (wr_en),
        .wr_addr   ({fill_bank, wr_x}),
        .wr_data   (fifo_data),
        .rd_en     (rd_req),
        .rd_addr   ({rd_bank, out_x[OXW-1:1]}),
        .rd_data   (rd_data_p0)
    );

    // p0: RAM read registered; a frame_start collision still produces a black slot.
    always_ff @(posedge clk_25Mhz) begin
        if (rst) begin
            req_p0 <= 1'b0;
            vld_p0 <= 1'b0;
        end else begin
            req_p0 <= out_ready && (emit_active || frame_start);
            vld_p0 <= rd_hit;
        end
    end

`ifdef PIXEL_UPSCALER_TEST_PATTERN_EN
    localparam int BAR_PX = (2 * SRC_W) / 8;
    logic [OXW-1:0] bar_idx;
    logic [2:0]     bar_p0;
    logic           tp_p0;

    assign bar_idx = out_x / OXW'(BAR_PX);

    always_ff @(posedge clk_25Mhz) begin
        bar_p0 <= bar_idx[2:0];
        if (rst) tp_p0 <= 1'b0;
        else     tp_p0 <= test_pattern && !frame_start;
    end
`endif

    always_comb begin
        pix_p1 = vld_p0 ? rgb565_to_888(rd_data_p0) : 24'd0;
        vld_p1 = vld_p0;
`ifdef PIXEL_UPSCALER_TEST_PATTERN_EN
        if (tp_p0) begin
            pix_p1 = bar_colour(bar_p0);
            vld_p1 = 1'b1;
        end
`endif
    end

    // p1: output register, holds between requests.
    always_ff @(posedge clk_25Mhz) begin
        if (rst) begin
            out_pixel <= '0;
            out_valid <= 1'b0;
        end else if (req_p0) begin
            out_pixel <= pix_p1;
            out_valid <= vld_p1;
        end
    end

endmodule

// File: tb/tb_pixel_upscaler_2x.sv
// Directed bench for pixel_upscaler_2x: fill/stall, doubled ramp lines, colour
// expansion, underflow, mid-frame restart and (when enabled) the colour bars.
`timescale 1ns/1ps
module tb_pixel_upscaler_2x;
    import pixel_upscaler_pkg::*;

    logic        clk_25Mhz = 1'b0;
    logic        rst;
    logic        frame_start;
    logic [15:0] fifo_data;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic        out_ready;
    logic [23:0] out_pixel;
    logic        out_valid;
    logic        underflow;
`ifdef PIXEL_UPSCALER_TEST_PATTERN_EN
    logic        test_pattern = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] fifo_mem [0:32767];
    int          head = 0;
    int          tail = 0;
    int          pops = 0;
    logic [15:0] line_ref [0:319];

    always #20 clk_25Mhz = ~clk_25Mhz;

    assign fifo_empty = (head == tail);
    assign fifo_data  = fifo_mem[head[14:0]];

    always @(posedge clk_25Mhz) begin
        if (fifo_rd_en && !fifo_empty) begin
            head <= head + 1;
            pops <= pops + 1;
        end
    end

    pixel_upscaler_2x dut (
        .clk_25Mhz   (clk_25Mhz),
        .rst         (rst),
        .frame_start (frame_start),
        .fifo_data   (fifo_data),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .out_ready   (out_ready),
`ifdef PIXEL_UPSCALER_TEST_PATTERN_EN
        .test_pattern(test_pattern),
`endif
        .out_pixel   (out_pixel),
        .out_valid   (out_valid),
        .underflow   (underflow)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] exp565(input logic [15:0] w);
        logic [7:0] r, g, b;
        r = {w[15:11], 3'b000} | {5'b00000, w[15:13]};
        g = {w[10:5], 2'b00}   | {6'b000000, w[10:9]};
        b = {w[4:0], 3'b000}   | {5'b00000, w[4:2]};
        return {r, g, b};
    endfunction

    task automatic push_word(input logic [15:0] w);
        fifo_mem[tail[14:0]] = w;
        tail++;
    endtask

    task automatic push_line_ref();
        for (int i = 0; i < 320; i++) push_word(line_ref[i]);
    endtask

    task automatic set_line_const(input logic [15:0] w);
        for (int i = 0; i < 320; i++) line_ref[i] = w;
    endtask

    task automatic pulse_frame();
        @(negedge clk_25Mhz);
        frame_start = 1'b1;
        @(negedge clk_25Mhz);
        frame_start = 1'b0;
    endtask

    task automatic wait_bank_full(input int b, input string tag);
        int cyc = 0;
        while (dut.bank_full[b] !== 1'b1 && cyc < 5000) begin
            @(negedge clk_25Mhz);
            cyc++;
        end
        check_eq(tag, 32'(dut.bank_full[b]), 32'd1);
    endtask

    // n reads starting at out_x = 0; output p appears two negedges after its request.
    task automatic emit_check(input int n, input bit exp_valid, input string tag);
        logic [24:0] e;
        e = '0;
        out_ready = 1'b1;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk_25Mhz);
            if (i == n - 1) out_ready = 1'b0;
            if (i >= 1) begin
                e = {exp_valid, exp_valid ? exp565(line_ref[((i - 1) % 640) >> 1]) : 24'd0};
                check_eq(tag, 32'({out_valid, out_pixel}), 32'(e));
            end
        end
        @(negedge clk_25Mhz);
        check_eq("hold", 32'({out_valid, out_pixel}), 32'(e));
    endtask

    initial begin
        rst         = 1'b1;
        frame_start = 1'b0;
        out_ready   = 1'b0;
        repeat (3) @(negedge clk_25Mhz);
        check_eq("rst_rd_en",  32'(fifo_rd_en), 32'd0);
        check_eq("rst_pixel",  32'(out_pixel), 32'd0);
        check_eq("rst_valid",  32'(out_valid), 32'd0);
        check_eq("rst_uflow",  32'(underflow), 32'd0);
        check_eq("rst_state",  32'(dut.fetch_state), 32'(F_IDLE));
        check_eq("rst_ctrs",   32'({dut.out_x, dut.out_y, dut.src_line, dut.bank_full}), 32'd0);
        rst = 1'b0;

        // Source lines: ramp, red, green, blue
        for (int i = 0; i < 320; i++) line_ref[i] = 16'(i);
        push_line_ref();
        for (int i = 0; i < 320; i++) push_word(16'hF800);
        for (int i = 0; i < 320; i++) push_word(16'h07E0);
        for (int i = 0; i < 320; i++) push_word(16'h001F);
        repeat (4) @(negedge clk_25Mhz);
        check_eq("idle_no_pop", 32'(pops), 32'd0);

        pulse_frame();
        wait_bank_full(0, "bank0_full");
        check_eq("pops_line0", 32'(pops), 32'd320);
        check_eq("rd_en_bank1", 32'(fifo_rd_en), 32'd1);
        wait_bank_full(1, "bank1_full");
        check_eq("pops_line1", 32'(pops), 32'd640);
        check_eq("stall_rd_en", 32'(fifo_rd_en), 32'd0);

        emit_check(640, 1'b1, "ramp_pass0");
        check_eq("bank0_kept", 32'(dut.bank_full[0]), 32'd1);
        emit_check(640, 1'b1, "ramp_pass1");
        check_eq("bank0_freed", 32'(dut.bank_full[0]), 32'd0);
        check_eq("rd_bank_1", 32'(dut.rd_bank), 32'd1);
        check_eq("out_y_2", 32'(dut.out_y), 32'd2);

        set_line_const(16'hF800);
        emit_check(1280, 1'b1, "red_lines");
        check_eq("red_888", 32'(out_pixel), 32'h00FF0000);
        set_line_const(16'h07E0);
        emit_check(1280, 1'b1, "green_lines");
        check_eq("green_888", 32'(out_pixel), 32'h0000FF00);
        set_line_const(16'h001F);
        emit_check(1280, 1'b1, "blue_lines");
        check_eq("blue_888", 32'(out_pixel), 32'h000000FF);
        check_eq("no_uflow", 32'(underflow), 32'd0);

        // Underflow: FIFO empty at the first active line
        pulse_frame();
        emit_check(640, 1'b0, "uflow_black");
        check_eq("uflow_set", 32'(underflow), 32'd1);
        check_eq("uflow_x_wrap", 32'(dut.out_x), 32'd0);
        check_eq("uflow_y", 32'(dut.out_y), 32'd1);
        pulse_frame();
        check_eq("uflow_clr", 32'(underflow), 32'd0);

`ifdef PIXEL_UPSCALER_TEST_PATTERN_EN
        test_pattern = 1'b1;
        out_ready    = 1'b1;
        for (int i = 0; i <= 640; i++) begin
            @(negedge clk_25Mhz);
            if (i == 639) out_ready = 1'b0;
            if (i >= 1 && i <= 80)  check_eq("bar_white", 32'({out_valid, out_pixel}), 32'h01FFFFFF);
            if (i >= 561)           check_eq("bar_black", 32'({out_valid, out_pixel}), 32'h01000000);
        end
        check_eq("bar_uflow", 32'(underflow), 32'd0);
        test_pattern = 1'b0;
        pulse_frame();
`endif

        // Mid-frame restart at out_y = 100, src_line = 52
        for (int i = 0; i < 53 * 320; i++) push_word(16'(i));
        wait_bank_full(1, "mid_prefill");
        out_ready = 1'b1;
        repeat (64400) @(negedge clk_25Mhz);
        out_ready = 1'b0;
        check_eq("mid_out_y", 32'(dut.out_y), 32'd100);
        check_eq("mid_out_x", 32'(dut.out_x), 32'd400);
        check_eq("mid_src_line", 32'(dut.src_line), 32'd52);
        check_eq("mid_uflow", 32'(underflow), 32'd0);
        tail = head;
        pulse_frame();
        check_eq("restart_ctrs", 32'({dut.out_x, dut.out_y, dut.src_line, dut.wr_x}), 32'd0);
        check_eq("restart_flags", 32'({dut.bank_full, dut.rd_bank, dut.fill_bank}), 32'd0);
        check_eq("restart_state", 32'(dut.fetch_state), 32'(F_FILL));
        set_line_const(16'h0000);
        line_ref[0] = 16'h1234;
        push_line_ref();
        wait_bank_full(0, "restart_bank0");
        emit_check(4, 1'b1, "restart_px");
        check_eq("restart_x4", 32'(dut.out_x), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
